// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and the baud divisor
// helper (also intended for the receive side).
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; depth must be a power of two so
// the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter. Define UART_TX_PARITY_EN to insert an even
// parity bit between the data bits and the stop period.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            tx_done
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(STOP_BITS * DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "uart_tx_fifo: baud divisor must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 line_active;
  logic                 fifo_rd;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [7:0]           fifo_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // Pop decision uses the level at the start of the cycle, so a fresh push is
  // never bypassed into the same cycle.
  assign fifo_rd  = (state == ST_IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign busy     = line_active || !fifo_empty || (state != ST_IDLE);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (in_valid),
    .wr_data(in_data),
    .rd_en  (fifo_rd),
    .rd_data(fifo_q),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // tx/tx_done/line_active are registered copies of the current state's line
  // value, so the whole frame appears on the pin one cycle after the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      line_active <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx          <= 1'b1;
          line_active <= 1'b0;
          cnt         <= '0;
          if (fifo_rd) state <= ST_START;
        end
        ST_START: begin
          tx          <= 1'b0;
          line_active <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= fifo_q;
`ifdef UART_TX_PARITY_EN
            parity  <= ^fifo_q;
`endif
            state   <= ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          tx          <= shift[0];
          line_active <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx          <= parity;
          line_active <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          tx          <= 1'b1;
          line_active <= 1'b1;
          if (cnt == STOP_LAST) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx          <= 1'b1;
          line_active <= 1'b0;
          cnt         <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: timeline reference model, per-cycle compare, serial
// line decoder with an expected-byte scoreboard, and directed/random stimulus.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD       = 1_000_000;
  localparam int FIFO_DEPTH = 16;
  localparam int STOP_BITS  = 1;
  localparam int DIV        = 50;  // (50e6 + 0.5e6) / 1e6, rounded down
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11 + STOP_BITS - 1;
  localparam bit PAR = 1'b1;
  localparam logic [10:0] SB_BITS = 11'b100_1001_0000;  // 0x48: start, LSB-first data, parity 0, stop
`else
  localparam int NB  = 10 + STOP_BITS - 1;
  localparam bit PAR = 1'b0;
  localparam logic [10:0] SB_BITS = 11'b110_1001_0000;  // 0x48: start, LSB-first data, stop
`endif
  localparam int FRAME = NB * DIV;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int WATCHDOG = 80000;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          tx_done;
  int            cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level),
    .tx_done   (tx_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO contents as a queue, current frame as time since pop.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         accepted = 0;
  bit         pop_now;
  bit         push_now;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_t = 0;
    end else begin
      pop_now  = (!m_active || m_t == FRAME) && (m_q.size() > 0);
      push_now = in_valid && (m_q.size() < FIFO_DEPTH);
      if (pop_now) begin
        m_cur = m_q.pop_front();
        exp_q.push_back(m_cur);
      end
      if (push_now) begin
        m_q.push_back(in_data);
        accepted++;
      end
      if (pop_now) begin
        m_active = 1'b1;
        m_t = 0;
      end else if (m_active) begin
        if (m_t == FRAME) m_active = 1'b0;
        else m_t++;
      end
    end
  end

  function automatic logic m_tx();
    int p;
    if (!m_active || m_t == 0) return 1'b1;
    p = (m_t - 1) / DIV;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_cur[p-1];
    if (PAR && p == 9) return ^m_cur;
    return 1'b1;
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("tx", tx, m_tx());
      check("busy", busy, m_active || (m_q.size() > 0));
      check("tx_done", tx_done, m_active && (m_t == FRAME));
      check("in_ready", in_ready, m_q.size() < FIFO_DEPTH);
      check("fifo_level", fifo_level, m_q.size());
    end
  end

  // Serial decoder and scoreboard against the bytes the model popped.
  bit          mon_busy = 1'b0;
  int          mon_cnt = 0;
  logic [10:0] mon_bits = '1;
  logic [7:0]  rx_byte;
  int          rx_count = 0;
  int          start_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (mon_busy) begin
      mon_cnt++;
      if (mon_cnt % DIV == DIV / 2) begin
        mon_bits[mon_cnt/DIV] = tx;
        if (mon_cnt / DIV == NB - 1) begin
          mon_busy = 1'b0;
          rx_byte = mon_bits[8:1];
          rx_count++;
          check("rx_start_bit", mon_bits[0], 1'b0);
          check("rx_stop_bit", mon_bits[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", mon_bits[9], ^rx_byte);
`endif
          check("rx_expected_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
        end
      end
    end else if (tx === 1'b0) begin
      mon_busy = 1'b1;
      mon_cnt = 0;
      start_q.push_back(cyc);
    end
  end

  // driver tasks (always entered and left on a falling edge)
  task automatic push_byte(input logic [7:0] b, output int k);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    k = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #(WATCHDOG * 20);
    $display("FAIL watchdog: run exceeded %0d cycles", WATCHDOG);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  int    k, k2, acc0, s0, lows, rx0;
  string msg = "Hello World!\n";

  initial begin
    // reset values
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // single byte 0x48: latency, bit pattern, tx_done position
    push_byte(8'h48, k);
    wait_until(k + 1);
    check("sb_tx_still_high", tx, 1'b1);
    wait_until(k + 2);
    check("sb_tx_fall", tx, 1'b0);
    for (int i = 0; i < NB; i++) begin
      wait_until(k + 2 + i * DIV + DIV / 2);
      check("sb_bit", tx, SB_BITS[i]);
    end
    wait_until(k + FRAME);
    check("sb_done_early", tx_done, 1'b0);
    wait_until(k + 1 + FRAME);
    check("sb_done_pulse", tx_done, 1'b1);
    wait_until(k + 2 + FRAME);
    check("sb_done_end", tx_done, 1'b0);
    check("sb_busy_end", busy, 1'b0);

    // burst of 18 bytes into a 16-deep FIFO; one pop happens during the burst
    acc0 = accepted;
    s0 = start_q.size();
    for (int i = 0; i < 18; i++) begin
      in_data  = (i < 13) ? msg[i] : 8'(8'hA0 + i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("burst_accepted", accepted - acc0, 17);
    check("burst_level_full", fifo_level, FIFO_DEPTH);
    check("burst_in_ready_low", in_ready, 1'b0);
    wait_idle("burst_drain", 20 * (FRAME + 1) + 100);
    check("burst_frames", start_q.size() - s0, 17);
    for (int j = s0 + 1; j < start_q.size(); j++)
      check("burst_gap", start_q[j] - start_q[j-1], FRAME + 1);
    check("burst_all_decoded", exp_q.size(), 0);

    // reset during data bit 3 of 0xA5 with three bytes queued behind it
    push_byte(8'hA5, k);
    push_byte(8'h11, k2);
    push_byte(8'h22, k2);
    push_byte(8'h33, k2);
    wait_until(k + 2 + 4 * DIV + DIV / 2);
    check("rm_level_before", fifo_level, 3);
    check("rm_bit3", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rm_tx_after", tx, 1'b1);
    check("rm_level_after", fifo_level, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rm_no_start", lows, 0);

    // push while a pop happens: level stays 1, both bytes go out in order
    rx0 = rx_count;
    push_byte(8'h5A, k);
    check("sim_level_first", fifo_level, 1);
    push_byte(8'hC3, k2);
    check("sim_level_same", fifo_level, 1);
    wait_idle("sim_drain", 3 * (FRAME + 1) + 100);
    check("sim_frames", rx_count - rx0, 2);

`ifdef UART_TX_PARITY_EN
    push_byte(8'h07, k);
    wait_idle("par07_drain", FRAME + 100);
    check("par07_bit9", mon_bits[9], 1'b1);
    check("par07_bit10", mon_bits[10], 1'b1);
    push_byte(8'h03, k);
    wait_idle("par03_drain", FRAME + 100);
    check("par03_bit9", mon_bits[9], 1'b0);
    check("par03_bit10", mon_bits[10], 1'b1);
`endif

    // random dense traffic (overflows the FIFO), then sparse traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 7) == 0);
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle("rand_dense_drain", 20 * (FRAME + 1) + 100);
    for (int i = 0; i < 12; i++) begin
      push_byte(8'($urandom_range(0, 255)), k);
      repeat ($urandom_range(0, FRAME + 20)) @(negedge clk);
    end
    wait_idle("rand_sparse_drain", 20 * (FRAME + 1) + 100);
    check("final_all_decoded", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
